// File: rtl/ram4k_arbiter_pkg.sv
// ============================================================================
// Module : ram4k_arbiter_pkg
// Brief  : Shared defaults, FSM encoding and requester ids for ram4k_arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram4k_arbiter_pkg;

    localparam int c_ADDR_W = 12;
    localparam int c_DATA_W = 16;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    typedef enum logic [1:0] {
        S_CLEAR  = 2'd0,
        S_IDLE   = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/ram4k_arbiter_rr_arb2.sv
// ============================================================================
// Module : rr_arb2
// Brief  : Two-way round-robin selector; grant is one-hot (bit index = id).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
    import ram4k_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        // Under contention the requester that was not served last wins.
        if (req == 2'b11) begin
            grant = (last == REQ_B) ? 2'b01 : 2'b10;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram4k_arbiter.sv
// ============================================================================
// Module : ram4k_arbiter
// Brief  : Two-requester round-robin front end for a single-port RAM4K.
//          Optional RAM4K_ARB_CLEAR_EN zero-fills the RAM after reset.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram4k_arbiter
    import ram4k_arbiter_pkg::*;
#(
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              we_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              done_a,
    output logic              done_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_in,
    input  logic [DATA_W-1:0] ram_out,
    output logic              busy
);

`ifdef RAM4K_ARB_CLEAR_EN
    localparam state_t c_RESET_STATE = S_CLEAR;
`else
    localparam state_t c_RESET_STATE = S_IDLE;
`endif

    state_t              r_state;
    state_t              w_next;
    logic                r_win;
    logic                r_last;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_done_a;
    logic                r_done_b;
    logic [DATA_W-1:0]   r_rdata_a;
    logic [DATA_W-1:0]   r_rdata_b;
    logic [1:0]          w_req;
    logic [1:0]          w_grant;
    logic                w_pick;

`ifdef RAM4K_ARB_CLEAR_EN
    logic [ADDR_W-1:0]   r_clr_cnt;
`endif

    assign w_req  = {req_b, req_a};
    assign w_pick = w_grant[REQ_B] ? REQ_B : REQ_A;

    rr_arb2 u_rr_arb2 (
        .req   (w_req),
        .last  (r_last),
        .grant (w_grant)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_RESET_STATE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (|w_req) w_next = S_ACCESS;
            S_ACCESS: w_next = S_IDLE;
`ifdef RAM4K_ARB_CLEAR_EN
            S_CLEAR:  if (r_clr_cnt == {ADDR_W{1'b1}}) w_next = S_IDLE;
`endif
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ram_load    = 1'b0;
        ram_address = '0;
        ram_in      = '0;
        case (r_state)
            S_ACCESS: begin
                ram_load    = r_we;
                ram_address = r_addr;
                ram_in      = r_wdata;
            end
`ifdef RAM4K_ARB_CLEAR_EN
            // Gated by reset so nothing is written while reset is held.
            S_CLEAR: begin
                ram_load    = ~reset;
                ram_address = r_clr_cnt;
            end
`endif
            default: ;
        endcase
    end

    assign gnt_a   = (r_state == S_ACCESS) && (r_win == REQ_A);
    assign gnt_b   = (r_state == S_ACCESS) && (r_win == REQ_B);
    assign busy    = (r_state != S_IDLE);
    assign done_a  = r_done_a;
    assign done_b  = r_done_b;
    assign rdata_a = r_rdata_a;
    assign rdata_b = r_rdata_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_win     <= REQ_A;
            r_last    <= REQ_B;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_done_a  <= 1'b0;
            r_done_b  <= 1'b0;
            r_rdata_a <= '0;
            r_rdata_b <= '0;
        end else begin
            r_done_a <= (r_state == S_ACCESS) && (r_win == REQ_A);
            r_done_b <= (r_state == S_ACCESS) && (r_win == REQ_B);
            if ((r_state == S_IDLE) && (|w_req)) begin
                r_win   <= w_pick;
                r_last  <= w_pick;
                r_we    <= (w_pick == REQ_B) ? we_b    : we_a;
                r_addr  <= (w_pick == REQ_B) ? addr_b  : addr_a;
                r_wdata <= (w_pick == REQ_B) ? wdata_b : wdata_a;
            end
            if (r_state == S_ACCESS) begin
                if (r_win == REQ_A) begin
                    r_rdata_a <= ram_out;
                end else begin
                    r_rdata_b <= ram_out;
                end
            end
        end
    end

`ifdef RAM4K_ARB_CLEAR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clr_cnt <= '0;
        end else if (r_state == S_CLEAR) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ram4k_arbiter.sv
// ============================================================================
// Module : tb_ram4k_arbiter
// Brief  : Self-checking bench: RAM4K model, directed and random two-requester
//          traffic against a slot-level round-robin model. Honours RAM4K_ARB_CLEAR_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram4k_arbiter;

`ifdef RAM4K_ARB_CLEAR_EN
    localparam bit c_CLR = 1'b1;
`else
    localparam bit c_CLR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_a = 1'b0, req_b = 1'b0, we_a = 1'b0, we_b = 1'b0;
    logic [11:0] addr_a = '0, addr_b = '0;
    logic [15:0] wdata_a = '0, wdata_b = '0;
    logic        gnt_a, gnt_b, done_a, done_b, ram_load, busy;
    logic [15:0] rdata_a, rdata_b, ram_in, ram_out;
    logic [11:0] ram_address;

    logic [15:0] ram_mem [4096];
    logic [15:0] ref_mem [4096];
    logic        ram_init = 1'b0;
    logic        tb_last;
    logic [15:0] exp_rdata_a, exp_rdata_b;
    int          n_checks = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    ram4k_arbiter dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b),
        .ram_load(ram_load), .ram_address(ram_address), .ram_in(ram_in),
        .ram_out(ram_out), .busy(busy)
    );

    // RAM4K model: combinational read, write on rising edge when load is high.
    assign ram_out = ram_mem[ram_address];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 4096; i++) begin
                ram_mem[i] <= c_CLR ? 16'(i ^ 32'h5A5A) : 16'h0000;
            end
        end else if (ram_load) begin
            ram_mem[ram_address] <= ram_in;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_gnt_a", {31'd0, gnt_a}, 0);
        check("rst_gnt_b", {31'd0, gnt_b}, 0);
        check("rst_done_a", {31'd0, done_a}, 0);
        check("rst_done_b", {31'd0, done_b}, 0);
        check("rst_rdata_a", {16'd0, rdata_a}, 0);
        check("rst_rdata_b", {16'd0, rdata_b}, 0);
        check("rst_ram_load", {31'd0, ram_load}, 0);
        check("rst_ram_address", {20'd0, ram_address}, 0);
        check("rst_ram_in", {16'd0, ram_in}, 0);
        check("rst_busy", {31'd0, busy}, {31'd0, c_CLR});
    endtask

    // Model consequences of a reset: round-robin pointer at B, rdata zero,
    // RAM zero-filled when the clear feature is built in.
    task automatic model_reset();
        tb_last     = 1'b1;
        exp_rdata_a = '0;
        exp_rdata_b = '0;
        if (c_CLR) begin
            for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
        end
    endtask

    task automatic wait_clear(input int expn);
        int n;
        n = 0;
        while (busy && n < 6000) begin
            @(posedge clk); #1;
            n++;
        end
        check("clear_cycles", n, expn);
    endtask

    // Requester A performs na identical accesses and B nb, both raised at once.
    // Slot i of the sequence has its grant in cycle 2i+1 and done in 2i+2.
    task automatic transact(input int na, input logic wa, input logic [11:0] aa, input logic [15:0] da,
                            input int nb, input logic wb, input logic [11:0] ab, input logic [15:0] db);
        int          win [16];
        int          ca, cb, ga, gb, tot, slot, w;
        bit          acc;
        logic        cur_we;
        logic [11:0] cur_addr;
        logic [15:0] cur_wd;
        ca = na; cb = nb; ga = 0; gb = 0; tot = na + nb;
        for (int i = 0; i < tot; i++) begin
            if (ca > 0 && cb > 0) w = (tb_last == 1'b1) ? 0 : 1;
            else if (ca > 0)      w = 0;
            else                  w = 1;
            win[i]  = w;
            tb_last = (w == 1);
            if (w == 0) ca--; else cb--;
        end
        req_a = (na > 0); we_a = wa; addr_a = aa; wdata_a = da;
        req_b = (nb > 0); we_b = wb; addr_b = ab; wdata_b = db;
        for (int n = 1; n <= 2 * tot; n++) begin
            @(posedge clk); #1;
            slot     = (n - 1) / 2;
            acc      = (n % 2 == 1);
            w        = win[slot];
            cur_we   = (w == 0) ? wa : wb;
            cur_addr = (w == 0) ? aa : ab;
            cur_wd   = (w == 0) ? da : db;
            if (!acc) begin
                if (w == 0) exp_rdata_a = ref_mem[cur_addr];
                else        exp_rdata_b = ref_mem[cur_addr];
                if (cur_we) ref_mem[cur_addr] = cur_wd;
            end
            check("gnt_a", {31'd0, gnt_a}, {31'd0, (acc && w == 0)});
            check("gnt_b", {31'd0, gnt_b}, {31'd0, (acc && w == 1)});
            check("done_a", {31'd0, done_a}, {31'd0, (!acc && w == 0)});
            check("done_b", {31'd0, done_b}, {31'd0, (!acc && w == 1)});
            check("busy", {31'd0, busy}, {31'd0, acc});
            check("ram_load", {31'd0, ram_load}, {31'd0, (acc && cur_we)});
            check("rdata_a", {16'd0, rdata_a}, {16'd0, exp_rdata_a});
            check("rdata_b", {16'd0, rdata_b}, {16'd0, exp_rdata_b});
            if (acc) begin
                if (w == 0) begin ga++; if (ga == na) req_a = 1'b0; end
                else        begin gb++; if (gb == nb) req_b = 1'b0; end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
        model_reset();

        // Power-up reset; the RAM model is preloaded while reset holds.
        reset = 1'b1; ram_init = 1'b1;
        @(posedge clk); #1;
        ram_init = 1'b0;
        check_reset_outputs();
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
`ifdef RAM4K_ARB_CLEAR_EN
        wait_clear(4096);
`endif

        // Contention straight after reset: A first, then B.
        transact(1, 1'b1, 12'd1000, 16'hB111, 1, 1'b1, 12'd2500, 16'hC222);
        transact(1, 1'b0, 12'd1000, 16'h0000, 1, 1'b0, 12'd2500, 16'h0000);
        // Single requester write then read of address 0.
        transact(1, 1'b1, 12'd0, 16'hA000, 0, 1'b0, 12'd0, 16'h0000);
        transact(1, 1'b0, 12'd0, 16'h0000, 0, 1'b0, 12'd0, 16'h0000);
        // Both hold req for three accesses each: strict alternation.
        transact(3, 1'b0, 12'd1000, 16'h0000, 3, 1'b0, 12'd2500, 16'h0000);
        // B alone holding req continuously.
        transact(0, 1'b0, 12'd0, 16'h0000, 4, 1'b0, 12'd0, 16'h0000);

        for (int k = 0; k < 24; k++) begin
            int na, nb;
            na = $urandom_range(0, 2);
            nb = $urandom_range(0, 2);
            if (na == 0 && nb == 0) na = 1;
            transact(na, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)), 16'($urandom),
                     nb, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)), 16'($urandom));
        end

        // Reset pulsed in the middle of an A write's ACCESS cycle.
        transact(0, 1'b0, 12'd0, 16'h0000, 1, 1'b1, 12'd4095, 16'hD333);
        req_a = 1'b1; we_a = 1'b1; addr_a = 12'd4095; wdata_a = 16'hEEEE;
        @(posedge clk); #1;
        check("abort_gnt_a", {31'd0, gnt_a}, 1);
        req_a = 1'b0;
        #2 reset = 1'b1;
        #1 check_reset_outputs();
        #1 reset = 1'b0;
        model_reset();
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            check("abort_done_a", {31'd0, done_a}, 0);
            check("abort_rdata_a", {16'd0, rdata_a}, 0);
        end
`ifdef RAM4K_ARB_CLEAR_EN
        wait_clear(4096 - 3);
`endif
        // Pointer is back at B, so A wins; A sees 4095 untouched by the aborted write.
        transact(1, 1'b0, 12'd4095, 16'h0000, 1, 1'b0, 12'd2500, 16'h0000);
        transact(1, 1'b0, 12'd2500, 16'h0000, 0, 1'b0, 12'd0, 16'h0000);
        check("final_4095", {16'd0, ref_mem[4095]}, c_CLR ? 32'h0 : 32'hD333);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
